// File: rtl/comple2_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : comple2_seq_ctrl_if                                             |
// | Purpose  : Operand stream, result stream, status and complement-unit       |
// |            signals between the sequencer and its surroundings.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface comple2_seq_ctrl_if #(
  parameter int CW = 3
);
  logic          start;
  logic [CW-1:0] words;
  logic          neg;
  logic [15:0]   in_word;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   out_word;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic          ovf;
  logic          zero;
  logic [15:0]   cu_a;
  logic          cu_cin;
  logic          cu_cmp;
  logic [15:0]   cu_r;

  // Environment side: operand source, result sink and the complement unit.
  modport master (
    output start, words, neg, in_word, in_valid, out_ready, cu_r,
    input  in_ready, out_word, out_valid, busy, done, err, ovf, zero,
           cu_a, cu_cin, cu_cmp
  );

  // Sequencer side.
  modport slave (
    input  start, words, neg, in_word, in_valid, out_ready, cu_r,
    output in_ready, out_word, out_valid, busy, done, err, ovf, zero,
           cu_a, cu_cin, cu_cmp
  );
endinterface
`default_nettype wire

// File: rtl/comple2_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : comple2_seq_ctrl                                                |
// | Purpose  : Streams 1..MAXW 16-bit words (LSW first) through the shared     |
// |            two's-complement unit, chaining the inter-word carry, and       |
// |            returns results through a single-entry output register.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module comple2_seq_ctrl #(
  parameter int MAXW = 4,
  parameter int CW   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  comple2_seq_ctrl_if.slave  bus
);

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_RUN   = 2'd1;
  localparam logic [1:0]    S_DRAIN = 2'd2;
  localparam logic [CW-1:0] c_maxw  = CW'(MAXW);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_words;
  logic [CW-1:0] r_cnt;
  logic          r_neg;
  logic          r_carry;
  logic          r_zacc;
  logic          r_ovf;
  logic          r_err;
  logic [15:0]   r_out_word;
  logic          r_out_valid;

  logic          w_words_ok;
  logic          w_xfer;
  logic          w_last;
  logic          w_accept;
  logic          w_in_ready;
  logic          w_busy;
  logic          w_done;
  logic          w_cu_cin;
  logic          w_cu_cmp;

  assign w_words_ok = (bus.words != '0) && (bus.words <= c_maxw);
  assign w_xfer     = bus.in_valid && w_in_ready;
  assign w_last     = (r_cnt == (r_words - CW'(1)));
  assign w_accept   = r_out_valid && bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode: launch on a legal start, drain after the last input word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start && w_words_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_xfer && w_last)        w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_accept)                w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: flow control, status and complement-unit controls.
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_cu_cin   = 1'b0;
    w_cu_cmp   = 1'b0;
    case (r_state)
      S_RUN: begin
        w_in_ready = !r_out_valid || bus.out_ready;
        w_busy     = 1'b1;
        w_cu_cin   = r_carry;
        w_cu_cmp   = r_neg;
      end
      S_DRAIN: begin
        w_busy     = 1'b1;
        w_done     = w_accept;
        w_cu_cin   = r_carry;
        w_cu_cmp   = r_neg;
      end
      default: ;
    endcase
  end

  // Datapath: latch operation fields, chain carry, accumulate flags, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words     <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_zacc      <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && bus.start && !w_words_ok;
      if ((r_state == S_IDLE) && bus.start && w_words_ok) begin
        r_words <= bus.words;
        r_neg   <= bus.neg;
        r_carry <= bus.neg;
        r_cnt   <= '0;
        r_zacc  <= 1'b1;
        r_ovf   <= 1'b0;
      end
      if (w_xfer) begin
        r_out_word  <= bus.cu_r;
        r_out_valid <= 1'b1;
        // Carry survives only through all-zero words of a negation.
        r_carry     <= r_carry && (bus.in_word == 16'h0000);
        r_zacc      <= r_zacc && (bus.cu_r == 16'h0000);
        r_cnt       <= r_cnt + CW'(1);
        if (w_last)
          r_ovf <= r_neg && r_carry && (bus.in_word == 16'h8000);
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_word  = r_out_word;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = r_err;
  assign bus.ovf       = w_done && r_ovf;
  assign bus.zero      = w_done && r_zacc;
  assign bus.cu_a      = bus.in_word;
  assign bus.cu_cin    = w_cu_cin;
  assign bus.cu_cmp    = w_cu_cmp;

endmodule
`default_nettype wire

// File: tb/tb_comple2_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_comple2_seq_ctrl                                             |
// | Purpose  : Directed self-checking bench for comple2_seq_ctrl, with a       |
// |            behavioural model of the complement unit.                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_comple2_seq_ctrl;

  localparam int MAXW = 4;
  localparam int CW   = 3;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  logic [15:0] vi[8];
  logic [15:0] ve[8];
  logic [63:0] x;
  logic [63:0] gold;

  comple2_seq_ctrl_if #(.CW(CW)) bus ();

  comple2_seq_ctrl #(.MAXW(MAXW), .CW(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Complement unit model.
  assign bus.cu_r = bus.cu_cmp ? 16'(~bus.cu_a + {15'd0, bus.cu_cin}) : bus.cu_a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_word"},  32'(bus.out_word),  32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_err"},       32'(bus.err),       32'd0);
    chk({tag, "_ovf"},       32'(bus.ovf),       32'd0);
    chk({tag, "_zero"},      32'(bus.zero),      32'd0);
    chk({tag, "_cu_cin"},    32'(bus.cu_cin),    32'd0);
    chk({tag, "_cu_cmp"},    32'(bus.cu_cmp),    32'd0);
    chk({tag, "_cu_a"},      32'(bus.cu_a),      32'(bus.in_word));
  endtask

  // One operation: inputs from vi[], expected outputs in ve[].
  task automatic op(input string tag, input int n, input bit ng, input bit eovf,
                    input bit ezero, input bit stall, input bit poke);
    int  idx;
    int  oidx;
    bit  got_done;
    bit  xin;
    idx      = 0;
    oidx     = 0;
    got_done = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.words = 3'(n);
    bus.neg   = ng;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
    for (int k = 0; k < 200 && !got_done; k++) begin
      if (poke) begin
        bus.start = (k == 0);
        bus.words = 3'd3;
        bus.neg   = ~ng;
      end
      bus.in_word   = (idx < n) ? vi[idx] : 16'h0;
      bus.in_valid  = (idx < n) && (stall ? ($urandom_range(0, 1) == 1) : 1'b1);
      bus.out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      chk({tag, "_cu_cmp"}, 32'(bus.cu_cmp), 32'(ng));
      if (bus.out_valid && !bus.out_ready)
        chk({tag, "_inrdy_stall"}, 32'(bus.in_ready), 32'd0);
      xin = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("%s_word%0d", tag, oidx), 32'(bus.out_word), 32'(ve[oidx]));
        oidx++;
      end
      if (bus.done) begin
        got_done = 1'b1;
        chk({tag, "_nwords"}, 32'(oidx), 32'(n));
        chk({tag, "_ovf"},    32'(bus.ovf),  32'(eovf));
        chk({tag, "_zero"},   32'(bus.zero), 32'(ezero));
        if (!stall) chk({tag, "_done_cyc"}, 32'(k + 1), 32'(n + 1));
      end
      if (xin) idx++;
      @(posedge clk); #1;
    end
    if (!got_done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.start     = 1'b0;
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.words     = '0;
    bus.neg       = 1'b0;
    bus.in_word   = 16'h5A5A;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset("idle");

    // Basic negate: -(0x0000_0001) = 0xFFFF_FFFF.
    vi[0] = 16'h0001; vi[1] = 16'h0000;
    ve[0] = 16'hFFFF; ve[1] = 16'hFFFF;
    op("neg2", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Carry chained through two zero low words.
    vi[0] = 16'h0000; vi[1] = 16'h0000; vi[2] = 16'h0001; vi[3] = 16'h0000;
    ve[0] = 16'h0000; ve[1] = 16'h0000; ve[2] = 16'hFFFF; ve[3] = 16'hFFFF;
    op("carry4", 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Most-negative 32-bit value overflows.
    vi[0] = 16'h0000; vi[1] = 16'h8000;
    ve[0] = 16'h0000; ve[1] = 16'h8000;
    op("mostneg", 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Negating zero gives zero, no overflow.
    vi[0] = 16'h0000; vi[1] = 16'h0000; vi[2] = 16'h0000;
    ve[0] = 16'h0000; ve[1] = 16'h0000; ve[2] = 16'h0000;
    op("zero3", 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Pass-through, including an 0x8000 top word.
    vi[0] = 16'h1234; vi[1] = 16'hABCD; vi[2] = 16'h8000;
    ve[0] = 16'h1234; ve[1] = 16'hABCD; ve[2] = 16'h8000;
    op("pass3", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single word at the lower length bound.
    vi[0] = 16'h0002;
    ve[0] = 16'hFFFE;
    op("neg1", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random backpressure and bubbles against the golden 64-bit negation.
    x    = 64'h8000_0000_0001_0000;
    gold = -x;
    for (int i = 0; i < 4; i++) begin
      vi[i] = x[16*i +: 16];
      ve[i] = gold[16*i +: 16];
    end
    chk("gold_top", 32'(gold[63:48]), 32'h7FFF);
    op("stall4", 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Start during RUN must not alter the latched length or mode.
    vi[0] = 16'h0001; vi[1] = 16'h0000;
    ve[0] = 16'hFFFF; ve[1] = 16'hFFFF;
    op("poke", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Illegal lengths.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.words = 3'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("err0_err",  32'(bus.err),  32'd1);
    chk("err0_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("err0_pulse", 32'(bus.err), 32'd0);
    bus.start = 1'b1; bus.words = 3'(MAXW + 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("err5_err",  32'(bus.err),  32'd1);
    chk("err5_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("err5_pulse", 32'(bus.err), 32'd0);

    // Abort after two of four words.
    bus.start = 1'b1; bus.words = 3'd4; bus.neg = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.in_word = 16'h0001;
    @(posedge clk); #1;
    bus.in_word = 16'h0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd1);
    chk("abort_ov",   32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    vi[0] = 16'h0001; vi[1] = 16'h0000;
    ve[0] = 16'hFFFF; ve[1] = 16'hFFFF;
    op("post_abort", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
